// File: rtl/cicero_axil_regs_if.sv
// cicero_axil_regs_if
// AXI4-Lite bus bundle between a host (master) and the CICERO register
// bank (slave).
//   Write address : s_awaddr, s_awvalid, s_awready
//   Write data    : s_wdata, s_wstrb, s_wvalid, s_wready
//   Write response: s_bresp, s_bvalid, s_bready
//   Read address  : s_araddr, s_arvalid, s_arready
//   Read data     : s_rdata, s_rresp, s_rvalid, s_rready
interface cicero_axil_regs_if #(
  parameter int REG_WIDTH      = 32,
  parameter int AXI_ADDR_WIDTH = 6
);
  logic [AXI_ADDR_WIDTH-1:0] s_awaddr;
  logic                      s_awvalid;
  logic                      s_awready;
  logic [REG_WIDTH-1:0]      s_wdata;
  logic [REG_WIDTH/8-1:0]    s_wstrb;
  logic                      s_wvalid;
  logic                      s_wready;
  logic [1:0]                s_bresp;
  logic                      s_bvalid;
  logic                      s_bready;
  logic [AXI_ADDR_WIDTH-1:0] s_araddr;
  logic                      s_arvalid;
  logic                      s_arready;
  logic [REG_WIDTH-1:0]      s_rdata;
  logic [1:0]                s_rresp;
  logic                      s_rvalid;
  logic                      s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/cicero_axil_regs.sv
// cicero_axil_regs
// AXI4-Lite register bank feeding the CICERO command/memory controller.
// Holds DIN_LO/DIN_HI/ADDRESS/START_CC/END_CC/CMD as level-held outputs and
// returns controller status and 64-bit read data to the host.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   s                    : AXI4-Lite slave (cicero_axil_regs_if.slave)
//   data_in_register     : {DIN_HI, DIN_LO}
//   address_register, start_cc_pointer_register, end_cc_pointer_register,
//   cmd_register         : held RW register values
//   status_register      : controller status (read at 0x18)
//   data_o_register      : controller 64-bit read data (0x1C / 0x20)
// Build option: CICERO_AXIL_DOUT_SNAPSHOT_EN -- when defined, a DOUT_LO read
// captures all 64 bits so a following DOUT_HI read is coherent with it.
module cicero_axil_regs #(
  parameter int REG_WIDTH      = 32,
  parameter int AXI_ADDR_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cicero_axil_regs_if.slave    s,
  output logic [63:0]          data_in_register,
  output logic [REG_WIDTH-1:0] address_register,
  output logic [REG_WIDTH-1:0] start_cc_pointer_register,
  output logic [REG_WIDTH-1:0] end_cc_pointer_register,
  output logic [REG_WIDTH-1:0] cmd_register,
  input  logic [REG_WIDTH-1:0] status_register,
  input  logic [63:0]          data_o_register
);
  localparam int IDX_W  = AXI_ADDR_WIDTH - 2;
  localparam int NUM_RW = 6;
  localparam int NB     = REG_WIDTH / 8;
  localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(6);
  localparam logic [IDX_W-1:0] IDX_DOUT_LO = IDX_W'(7);
  localparam logic [IDX_W-1:0] IDX_DOUT_HI = IDX_W'(8);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_VALID} r_state_e;

  // Byte-lane bits of the addresses carry no meaning for word registers.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, s.s_awaddr[1:0], s.s_araddr[1:0]};

  // ---------------- write path ----------------
  logic                 aw_full_q, w_full_q;
  logic [IDX_W-1:0]     aw_idx_q;
  logic [REG_WIDTH-1:0] w_data_q;
  logic [NB-1:0]        w_strb_q;
  logic                 bvalid_q;
  logic [1:0]           bresp_q;
  logic [REG_WIDTH-1:0] rw_q [NUM_RW];

  logic                 aw_have, w_have, commit, wr_hit;
  logic [IDX_W-1:0]     wr_idx;
  logic [REG_WIDTH-1:0] wr_data;
  logic [NB-1:0]        wr_strb;

  assign s.s_awready = ~aw_full_q;
  assign s.s_wready  = ~w_full_q;
  assign s.s_bvalid  = bvalid_q;
  assign s.s_bresp   = bresp_q;

  // A channel arriving on the bus this cycle bypasses its latch, so AW and W
  // presented together commit on the very next edge.
  assign aw_have = aw_full_q | s.s_awvalid;
  assign w_have  = w_full_q  | s.s_wvalid;
  assign wr_idx  = aw_full_q ? aw_idx_q : s.s_awaddr[AXI_ADDR_WIDTH-1:2];
  assign wr_data = w_full_q  ? w_data_q : s.s_wdata;
  assign wr_strb = w_full_q  ? w_strb_q : s.s_wstrb;
  assign commit  = aw_have & w_have & ~bvalid_q;
  assign wr_hit  = (wr_idx < IDX_W'(NUM_RW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_full_q <= 1'b0;
      end else if (s.s_awvalid && !aw_full_q) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= s.s_awaddr[AXI_ADDR_WIDTH-1:2];
      end
      if (commit) begin
        w_full_q <= 1'b0;
      end else if (s.s_wvalid && !w_full_q) begin
        w_full_q <= 1'b1;
        w_data_q <= s.s_wdata;
        w_strb_q <= s.s_wstrb;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && s.s_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RW; i++) rw_q[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_strb[b]) rw_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  assign data_in_register          = {rw_q[1][31:0], rw_q[0][31:0]};
  assign address_register          = rw_q[2];
  assign start_cc_pointer_register = rw_q[3];
  assign end_cc_pointer_register   = rw_q[4];
  assign cmd_register              = rw_q[5];

  // ---------------- read path ----------------
  r_state_e             r_state_q, r_state_d;
  logic                 ar_hs;
  logic [IDX_W-1:0]     rd_idx;
  logic [REG_WIDTH-1:0] rd_data_d, rdata_q;
  logic [1:0]           rd_resp_d, rresp_q;

  assign rd_idx    = s.s_araddr[AXI_ADDR_WIDTH-1:2];
  assign ar_hs     = s.s_arvalid & (r_state_q == R_IDLE);
  assign s.s_rdata = rdata_q;
  assign s.s_rresp = rresp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state_q <= R_IDLE;
    else        r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (s.s_arvalid) r_state_d = R_VALID;
      R_VALID: if (s.s_rready)  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s.s_arready = (r_state_q == R_IDLE);
    s.s_rvalid  = (r_state_q == R_VALID);
  end

`ifdef CICERO_AXIL_DOUT_SNAPSHOT_EN
  logic [63:0] snap_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             snap_q <= '0;
    else if (ar_hs && rd_idx == IDX_DOUT_LO) snap_q <= data_o_register;
  end
`endif

  always_comb begin
    rd_data_d = '0;
    rd_resp_d = RESP_OKAY;
    if (rd_idx < IDX_W'(NUM_RW)) begin
      rd_data_d = rw_q[rd_idx[2:0]];
    end else if (rd_idx == IDX_STATUS) begin
      rd_data_d = status_register;
    end else if (rd_idx == IDX_DOUT_LO) begin
      rd_data_d = REG_WIDTH'(data_o_register[31:0]);
    end else if (rd_idx == IDX_DOUT_HI) begin
`ifdef CICERO_AXIL_DOUT_SNAPSHOT_EN
      rd_data_d = REG_WIDTH'(snap_q[63:32]);
`else
      rd_data_d = REG_WIDTH'(data_o_register[63:32]);
`endif
    end else begin
      rd_resp_d = RESP_SLVERR;
    end
  end

  // Read data is captured from the pre-edge register state, so a read that
  // coincides with a write to the same register sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_data_d;
      rresp_q <= rd_resp_d;
    end
  end
endmodule

// File: tb/tb_cicero_axil_regs.sv
// tb_cicero_axil_regs
// Directed and randomized bench for cicero_axil_regs. Expected values come
// from a word-array model of the register map.
// Honours CICERO_AXIL_DOUT_SNAPSHOT_EN in its DOUT_HI expectation.
module tb_cicero_axil_regs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] data_in_register;
  logic [31:0] address_register, start_cc_pointer_register;
  logic [31:0] end_cc_pointer_register, cmd_register;
  logic [31:0] status_val = '0;
  logic [63:0] dout_val = '0;

  int checks = 0;
  int errors = 0;

  // behavioural model
  logic [31:0] m_reg [6];
  logic [63:0] m_snap;

  cicero_axil_regs_if #(.REG_WIDTH(32), .AXI_ADDR_WIDTH(6)) bus ();

  cicero_axil_regs #(.REG_WIDTH(32), .AXI_ADDR_WIDTH(6)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .s                         (bus),
    .data_in_register          (data_in_register),
    .address_register          (address_register),
    .start_cc_pointer_register (start_cc_pointer_register),
    .end_cc_pointer_register   (end_cc_pointer_register),
    .cmd_register              (cmd_register),
    .status_register           (status_val),
    .data_o_register           (dout_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_reg[i] = '0;
    m_snap = '0;
  endtask

  function automatic logic [1:0] model_write(input logic [5:0] addr, input logic [31:0] data,
                                              input logic [3:0] strb);
    int idx = int'(addr) / 4;
    if (idx >= 6) return 2'b10;
    for (int b = 0; b < 4; b++)
      if (strb[b]) m_reg[idx][b*8 +: 8] = data[b*8 +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [5:0] addr);
    int idx = int'(addr) / 4;
    if (idx < 6) return {2'b00, m_reg[idx]};
    if (idx == 6) return {2'b00, status_val};
    if (idx == 7) begin
      m_snap = dout_val;
      return {2'b00, dout_val[31:0]};
    end
`ifdef CICERO_AXIL_DOUT_SNAPSHOT_EN
    if (idx == 8) return {2'b00, m_snap[63:32]};
`else
    if (idx == 8) return {2'b00, dout_val[63:32]};
`endif
    return {2'b10, 32'h0};
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_din"},   data_in_register, {m_reg[1], m_reg[0]});
    chk({tag, "_addr"},  64'(address_register), 64'(m_reg[2]));
    chk({tag, "_start"}, 64'(start_cc_pointer_register), 64'(m_reg[3]));
    chk({tag, "_end"},   64'(end_cc_pointer_register), 64'(m_reg[4]));
    chk({tag, "_cmd"},   64'(cmd_register), 64'(m_reg[5]));
  endtask

  // Called at posedge+1; returns at posedge+1 after the B handshake.
  task automatic axi_write(input string tag, input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0, bw = 0;
    logic [1:0] exp_resp;
    bus.s_awaddr = addr;
    bus.s_wdata  = data;
    bus.s_wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 30) begin
      bus.s_awvalid = !aw_done && cyc >= aw_dly;
      bus.s_wvalid  = !w_done && cyc >= w_dly;
      aw_hs = bus.s_awvalid && bus.s_awready;
      w_hs  = bus.s_wvalid && bus.s_wready;
      @(posedge clk); #1;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      cyc++;
    end
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    chk({tag, "_handshakes"}, 64'({aw_done, w_done}), 64'(2'b11));
    exp_resp = model_write(addr, data, strb);
    while (!bus.s_bvalid && bw < 20) begin
      @(posedge clk); #1;
      bw++;
    end
    chk({tag, "_b_latency"}, 64'(bw), 64'(0));
    chk({tag, "_bresp"}, 64'(bus.s_bresp), 64'(exp_resp));
    check_outputs(tag);
    $display("WR %s addr=%h data=%h strb=%h resp=%0d", tag, addr, data, strb, bus.s_bresp);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input string tag, input logic [5:0] addr);
    bit done = 0;
    int n = 0;
    logic [33:0] exp;
    exp = '0;
    bus.s_araddr  = addr;
    bus.s_arvalid = 1'b1;
    while (!done && n < 20) begin
      done = bus.s_arready;
      if (done) exp = model_read(addr);
      @(posedge clk); #1;
      n++;
    end
    bus.s_arvalid = 1'b0;
    chk({tag, "_ar_hs"}, 64'(done), 64'(1));
    chk({tag, "_rvalid"}, 64'(bus.s_rvalid), 64'(1));
    chk({tag, "_rdata"}, 64'(bus.s_rdata), 64'(exp[31:0]));
    chk({tag, "_rresp"}, 64'(bus.s_rresp), 64'(exp[33:32]));
    $display("RD %s addr=%h data=%h resp=%0d", tag, addr, bus.s_rdata, bus.s_rresp);
    @(posedge clk); #1;
  endtask

  task automatic drive_both(input logic [5:0] addr, input logic [31:0] data);
    bus.s_awaddr = addr; bus.s_wdata = data; bus.s_wstrb = 4'hF;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
  endtask

  initial begin
    logic [1:0] r;
    int bw;
    bus.s_awaddr = '0; bus.s_awvalid = 0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_wvalid = 0; bus.s_bready = 1; bus.s_araddr = '0; bus.s_arvalid = 0;
    bus.s_rready = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    chk("rst_awready", 64'(bus.s_awready), 64'(1));
    chk("rst_wready",  64'(bus.s_wready), 64'(1));
    chk("rst_arready", 64'(bus.s_arready), 64'(1));
    chk("rst_bvalid",  64'(bus.s_bvalid), 64'(0));
    chk("rst_rvalid",  64'(bus.s_rvalid), 64'(0));
    check_outputs("rst");
    axi_read("rd_cmd_rst", 6'h14);

    // directed writes
    axi_write("din_hi", 6'h04, 32'hDEADBEEF, 4'hF, 0, 2);
    axi_write("din_lo_strb", 6'h00, 32'h12345678, 4'h3, 0, 0);
    chk("din_lo_val", 64'(data_in_register[31:0]), 64'(32'h00005678));
    axi_write("wr_status_ro", 6'h18, 32'hFFFFFFFF, 4'hF, 1, 0);
    axi_write("wr_unmapped", 6'h30, 32'hA5A5A5A5, 4'hF, 0, 0);
    axi_read("rd_unmapped", 6'h30);
    axi_write("addr_lowbits", 6'h0B, 32'hCAFE0001, 4'hF, 0, 0);
    axi_read("rd_addr", 6'h08);

    // B backpressure: second write must wait in the latches
    bus.s_bready = 1'b0;
    drive_both(6'h08, 32'h0000AAAA);
    chk("bp_first_bvalid", 64'(bus.s_bvalid), 64'(1));
    chk("bp_first_addr", 64'(address_register), 64'(32'h0000AAAA));
    r = model_write(6'h08, 32'h0000AAAA, 4'hF);
    drive_both(6'h0C, 32'h0000BBBB);
    chk("bp_awready_low", 64'(bus.s_awready), 64'(0));
    chk("bp_wready_low", 64'(bus.s_wready), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_commit", 64'(start_cc_pointer_register), 64'(m_reg[3]));
    bus.s_bready = 1'b1;
    @(posedge clk); #1;
    bw = 0;
    while (!bus.s_bvalid && bw < 20) begin
      @(posedge clk); #1;
      bw++;
    end
    r = model_write(6'h0C, 32'h0000BBBB, 4'hF);
    chk("bp_second_bvalid", 64'(bus.s_bvalid), 64'(1));
    chk("bp_second_bresp", 64'(bus.s_bresp), 64'(r));
    check_outputs("bp_after");
    $display("BP second write resp=%0d after %0d cycles", bus.s_bresp, bw);
    @(posedge clk); #1;

    // same-cycle read and write of ADDRESS: read sees old value
    bus.s_araddr = 6'h08; bus.s_arvalid = 1'b1;
    bus.s_awaddr = 6'h08; bus.s_wdata = 32'h5555AAAA; bus.s_wstrb = 4'hF;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    chk("rw_same_old_pre", 64'(bus.s_arready), 64'(1));
    begin
      logic [31:0] old_v;
      old_v = m_reg[2];
      @(posedge clk); #1;
      bus.s_arvalid = 1'b0; bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
      r = model_write(6'h08, 32'h5555AAAA, 4'hF);
      chk("rw_same_rdata_old", 64'(bus.s_rdata), 64'(old_v));
      chk("rw_same_addr_new", 64'(address_register), 64'(32'h5555AAAA));
      $display("RW same-cycle rdata=%h reg=%h", bus.s_rdata, address_register);
    end
    @(posedge clk); #1;

    // status and dout
    status_val = 32'h0BADF00D;
    axi_read("rd_status", 6'h18);
    dout_val = 64'h11112222_33334444;
    axi_read("rd_dout_lo", 6'h1C);
    dout_val = 64'h55556666_77778888;
    axi_read("rd_dout_hi", 6'h20);

    // randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      logic [5:0] a;
      if ($urandom_range(0, 4) == 0) status_val = $urandom;
      if ($urandom_range(0, 4) == 0) dout_val = {$urandom, $urandom};
      a = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1)
        axi_write($sformatf("rnd%0d", it), a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 2), $urandom_range(0, 2));
      else
        axi_read($sformatf("rnd%0d", it), a);
    end

    // reset in the middle of a read response and a half-delivered write
    axi_write("pre_rst_cmd", 6'h14, 32'h00000007, 4'hF, 0, 0);
    bus.s_rready = 1'b0;
    bus.s_araddr = 6'h14; bus.s_arvalid = 1'b1;
    bus.s_awaddr = 6'h00; bus.s_awvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0; bus.s_awvalid = 1'b0;
    chk("mid_rvalid_before", 64'(bus.s_rvalid), 64'(1));
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rvalid_async", 64'(bus.s_rvalid), 64'(0));
    chk("mid_bvalid_async", 64'(bus.s_bvalid), 64'(0));
    check_outputs("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.s_rready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_arready", 64'(bus.s_arready), 64'(1));
    chk("post_rst_awready", 64'(bus.s_awready), 64'(1));
    bus.s_wdata = 32'hFFFFFFFF; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_wvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_commit", 64'(bus.s_bvalid), 64'(0));
    check_outputs("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cicero_axil_regs.md
# cicero_axil_regs

AXI4-Lite slave register bank that sits directly upstream of the CICERO command/memory controller. It turns host bus transactions into the level-held configuration registers the controller samples every cycle (data in, address, CC pointers, command). It returns the controller's status and 64-bit read data to the host. Holding registers are the only state; the controller's command semantics are not interpreted here.

## Interface
- `REG_WIDTH`, default 32: AXI data width and width of the address, CC-pointer, command and status registers.
- `AXI_ADDR_WIDTH`, default 6: byte address width; registers are 32-bit words at 4-byte stride.
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous and active-low.
- `s_awaddr` in AXI_ADDR_WIDTH, `s_awvalid` in 1, `s_awready` out 1: write address channel.
- `s_wdata` in REG_WIDTH, `s_wstrb` in REG_WIDTH/8, `s_wvalid` in 1, `s_wready` out 1: write data channel.
- `s_bresp` out 2, `s_bvalid` out 1, `s_bready` in 1: write response channel.
- `s_araddr` in AXI_ADDR_WIDTH, `s_arvalid` in 1, `s_arready` out 1: read address channel.
- `s_rdata` out REG_WIDTH, `s_rresp` out 2, `s_rvalid` out 1, `s_rready` in 1: read data channel.
- `data_in_register` out 64: {DIN_HI, DIN_LO}.
- `address_register`, `start_cc_pointer_register`, `end_cc_pointer_register`, `cmd_register` out REG_WIDTH: held register values.
- `status_register` in REG_WIDTH, `data_o_register` in 64: status and read data from the controller.

## Operation
- Register map (byte offset): 0x00 DIN_LO RW, 0x04 DIN_HI RW, 0x08 ADDRESS RW, 0x0C START_CC RW, 0x10 END_CC RW, 0x14 CMD RW, 0x18 STATUS RO, 0x1C DOUT_LO RO, 0x20 DOUT_HI RO.
- All RW registers drive their output ports continuously. CMD is level-held: it stays until the host overwrites it. The host sequences command then NOP.
- Write path, AW and W independent:
  - Each channel has a one-entry holding latch; `s_awready` = AW latch empty, `s_wready` = W latch empty.
  - When both latches are full and B is idle, the write commits: only bytes with `s_wstrb` set are updated.
  - Both latches clear on commit and `s_bvalid` rises.
- Write response: OKAY (2'b00) for an RW offset. SLVERR (2'b10) for an RO or unmapped offset; such a write changes no register.
- Read path: states R_IDLE and R_VALID.
  - R_IDLE: `s_arready`=1. On AR handshake, register `s_rdata`/`s_rresp` and go to R_VALID.
  - R_VALID: `s_arready`=0 and `s_rvalid`=1. Return to R_IDLE on `s_rready`.
- Read data: RW offsets return the stored value. STATUS returns `status_register` sampled at the AR handshake. Unmapped offsets return 0 with SLVERR.
- Address decode uses `addr[AXI_ADDR_WIDTH-1:2]`; bits [1:0] are ignored.

## Timing
- Reset (asynchronous assert, synchronous release):
  - All RW registers are 0, so `data_in_register`=0 and `cmd_register`=0 (NOP).
  - `s_bvalid`=0, `s_rvalid`=0, both write latches empty.
  - `s_awready`=`s_wready`=`s_arready`=1.
- Write latency: AW and W in the same cycle means the register output updates and `s_bvalid`=1 on the next edge.
- B backpressure: while `s_bvalid`=1 and `s_bready`=0, no new commit occurs. Latches may fill, then `s_awready`/`s_wready` drop.
- Read latency: `s_rvalid` is asserted 1 cycle after the AR handshake; at most one read is outstanding.
- Same-cycle read and write to the same register: the read returns the pre-write value.
- Reset asserted mid-transaction: outstanding B/R responses are dropped, registers return to 0, and no partial write is committed.

## Configuration
- `CICERO_AXIL_DOUT_SNAPSHOT_EN`:
  - Defined: a read of DOUT_LO captures all 64 bits of `data_o_register` into a snapshot register. DOUT_LO returns the low half of the capture. DOUT_HI returns the snapshot's high half, which is unchanged until the next DOUT_LO read; the snapshot resets to 0.
  - Undefined: DOUT_LO and DOUT_HI each sample `data_o_register` live at their own AR handshake; there is no snapshot register.

## Test plan
- Reset, then read 0x14 → RDATA 0x0, RRESP OKAY. `cmd_register`=0, `data_in_register`=0.
- AW (0x04) two cycles before W (0xDEADBEEF, strb 0xF) → `data_in_register[63:32]`=0xDEADBEEF one cycle after W; BRESP OKAY. Then write 0x00 = 0x12345678 with strb 0x3 → low half 0x00005678.
- Write 0x18 or 0x30 → BRESP SLVERR, no output changes. Read 0x30 → RDATA 0, RRESP SLVERR.
- Hold `s_bready`=0 and issue two writes → second write not committed, `s_awready`=0 after latch fill. Release → second BRESP follows, both values landed in order.
- Drive `data_o_register`=0x11112222_33334444, read 0x1C, change input to 0x55556666_77778888, read 0x20 → 0x11112222 with macro, 0x55556666 without.
- Assert `rst_n` low while `s_rvalid`=1 → `s_rvalid`=0 asynchronously, all outputs 0, `s_arready`=1 after release.
